// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS multiply/divide definitions: md_op encodings used by the control
// decoder and by the HI/LO unit, plus the default multi-cycle latencies.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W        = 4;
    localparam int MD_MAX_CYCLES   = (1 << MD_CNT_W) - 1;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_multi_cycle(input logic [2:0] op);
        logic res;
        res = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the 5-stage MIPS pipeline. Multi-cycle
// operations latch their operands, count down a fixed latency and write
// {hi,lo} on the edge that ends BUSY. The stall output holds a dependent
// D-stage instruction until the new HI/LO values are architectural.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    // The countdown is MD_CNT_W bits wide; latencies must fit and be non-zero.
    if (MULT_CYCLES < 1 || MULT_CYCLES > MD_MAX_CYCLES ||
        DIV_CYCLES  < 1 || DIV_CYCLES  > MD_MAX_CYCLES) begin : g_bad_cycles
        $error("mult_div_unit: MULT_CYCLES/DIV_CYCLES must be in 1..15");
    end

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e             state;
    md_state_e             state_next;
    logic [MD_CNT_W-1:0]   cnt;
    logic [31:0]           op_a;
    logic [31:0]           op_b;
    logic [2:0]            op_q;
    logic                  multi_op;
    logic                  accept;
    logic                  last;
    logic [63:0]           md_result;

    // Signed or unsigned 64-bit product, returned as {hi,lo}.
    function automatic logic [63:0] mult_result(input logic sgn,
                                                input logic [31:0] x,
                                                input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        logic [63:0]        up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        sp = sx * sy;
        up = {32'd0, x} * {32'd0, y};
        return sgn ? 64'(sp) : up;
    endfunction

    // Quotient truncated toward zero in lo, remainder with the dividend's
    // sign in hi. Divide-by-zero and the signed overflow case get fixed
    // MIPS-compatible results instead of relying on the '/' operator.
    function automatic logic [63:0] div_result(input logic sgn,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [63:0]        res;
        sx = x;
        sy = y;
        if (y == 32'd0) begin
            res = {x, 32'hFFFF_FFFF};
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            res = {32'd0, 32'h8000_0000};
        end else if (sgn) begin
            sq  = sx / sy;
            sr  = sx % sy;
            res = {32'(sr), 32'(sq)};
        end else begin
            res = {x % y, x / y};
        end
        return res;
    endfunction

    assign multi_op = is_multi_cycle(md_op);
    assign busy     = (state == ST_BUSY);
    assign accept   = (state == ST_IDLE) && start && multi_op;
    assign last     = busy && (cnt <= MD_CNT_W'(1));
    assign stall    = md_use_d & (busy | (start & multi_op));

    // Result of the latched operation, valid for the whole BUSY period.
    always_comb begin
        md_result = 64'd0;
        case (op_q)
            MD_MULT:  md_result = mult_result(1'b1, op_a, op_b);
            MD_MULTU: md_result = mult_result(1'b0, op_a, op_b);
            MD_DIV:   md_result = div_result(1'b1, op_a, op_b);
            MD_DIVU:  md_result = div_result(1'b0, op_a, op_b);
            default:  md_result = 64'd0;
        endcase
    end

    // Next-state logic: accept a multi-cycle op in IDLE, leave BUSY when the count expires.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: if (last)   state_next = ST_IDLE;
            default:             state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latency counter: load on accept, count down while BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
        end else if (busy) begin
            cnt <= cnt - MD_CNT_W'(1);
        end
    end

    // Operand latch; held for the whole BUSY period so a later start cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= b;
            op_q <= md_op;
        end
    end

    // HI/LO registers: result write at the end of BUSY, direct writes for MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (last) begin
            hi <= md_result[63:32];
            lo <= md_result[31:0];
        end else if (state == ST_IDLE && start) begin
            if (md_op == MD_MTHI) hi <= a;
            if (md_op == MD_MTLO) lo <= a;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed operations with hand-computed HI/LO
// values queued as expectations; a monitor compares them, together with the
// busy duration, each time busy falls.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_busy = 1'b0;
    logic prev_rst  = 1'b1;
    int   busy_cnt  = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: on each busy falling edge not caused by reset, pop and compare.
    always @(negedge clk) begin
        if (prev_busy === 1'b1 && busy === 1'b0 && prev_rst === 1'b0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: hi=%h lo=%h with no pending expectation", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                chk("result_hi", hi, mon_e.hi);
                chk("result_lo", lo, mon_e.lo);
                chk("busy_cycles", 32'(busy_cnt), 32'(mon_e.cycles));
            end
        end
        if (busy === 1'b1) busy_cnt = (prev_busy === 1'b1) ? busy_cnt + 1 : 1;
        else busy_cnt = 0;
        prev_busy = busy;
        prev_rst  = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
        tick();
        tick();
    endtask

    task automatic issue(input string name, input logic [2:0] op,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.cycles = cyc;
        md_op = op;
        a = aa;
        b = bb;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        reset = 1'b1; start = 1'b0; md_use_d = 1'b0;
        md_op = 3'd0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        md_use_d = 1'b1;
        tick();
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);

        // MULT with a dependent mflo waiting in D.
        md_op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA; e.cycles = 5;
        sb.push_back(e);
        #1;
        chk("stall_on_start", 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        n = 1;
        while (stall && n < 40) begin
            n++;
            tick();
        end
        chk("stall_cycles", 32'(n), 32'd6);
        chk("mflo_after_stall", lo, 32'hFFFF_FFFA);
        md_use_d = 1'b0;
        tick();

        issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue("mult_neg_neg", MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 5);
        issue("mult_min_x2", MD_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, 5);
        issue("multu_min_x2", MD_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000, 5);
        issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        issue("divu_by_zero", MD_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 10);
        issue("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

        // MTHI / MTLO write directly with no BUSY period.
        md_op = MD_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_lo_kept", lo, 32'h8000_0000);
        chk("mthi_busy", 32'(busy), 32'd0);
        md_op = MD_MTLO; a = 32'h1357_9BDF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h1357_9BDF);
        chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

        // Unknown op code leaves everything unchanged.
        md_op = 3'd6; a = 32'h0BAD_0BAD; start = 1'b1;
        tick();
        start = 1'b0;
        chk("unknown_hi", hi, 32'hDEAD_BEEF);
        chk("unknown_lo", lo, 32'h1357_9BDF);
        chk("unknown_busy", 32'(busy), 32'd0);
        tick();

        // start held into BUSY with different operands must be ignored.
        md_op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        e.hi = 32'd0; e.lo = 32'd42; e.cycles = 5;
        sb.push_back(e);
        tick();
        md_op = MD_DIV; a = 32'd99; b = 32'd0;
        tick();
        tick();
        tick();
        start = 1'b0;
        wait_idle("start_in_busy");

        // Reset in busy cycle 3 of a DIV aborts it.
        md_op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (15) tick();
        chk("abort_no_late_hi", hi, 32'd0);
        chk("abort_no_late_lo", lo, 32'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; md_op = MD_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("reset_prio_busy", 32'(busy), 32'd0);
        repeat (8) tick();
        chk("reset_prio_lo", lo, 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, the busy duration of a MULT or MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, the busy duration of a DIV or DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: the E-stage instruction is a multiply/divide or HI/LO-write operation.
REQ-006 The block SHALL have port md_op, input, 3 bits: operation code from the shared package (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-007 The block SHALL have ports a and b, inputs, 32 bits each: forwarded rs and rt operands from the E stage.
REQ-008 The block SHALL have port md_use_d, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-009 The block SHALL have ports hi and lo, outputs, 32 bits each: architectural HI and LO registers.
REQ-010 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 The block SHALL have port stall, output, 1 bit: request to freeze PC and F/D and to clear D/E, ORed into the existing pause signal.

Function
REQ-012 The block SHALL implement a two-state machine, IDLE and BUSY, plus a 4-bit down-counter.
REQ-013 In IDLE, on an edge with start=1 and md_op of MULT/MULTU/DIV/DIVU, the block SHALL latch a, b and md_op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 busy SHALL be 1 in exactly the N cycles following the accepting edge (N = MULT_CYCLES or DIV_CYCLES), then 0.
REQ-015 The block SHALL update hi and lo on the edge that ends BUSY; hi and lo SHALL hold their previous values throughout BUSY.
REQ-016 MULT SHALL produce the signed 64-bit product and MULTU the unsigned 64-bit product, with {hi,lo} = product.
REQ-017 DIV/DIVU SHALL set lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend (signed or unsigned as selected).
REQ-018 Divide by zero SHALL set lo = 0xFFFFFFFF and hi = a; the signed overflow case 0x80000000 / -1 SHALL set lo = 0x80000000 and hi = 0.
REQ-019 In IDLE, on an edge with start=1 and md_op=MTHI (MTLO), the block SHALL write hi (lo) = a on that edge, with no BUSY period.
REQ-020 start during BUSY SHALL be ignored; the stall guarantees this cannot occur legally.
REQ-021 stall SHALL be combinational: stall = md_use_d & (busy | (start & md_op in {MULT, MULTU, DIV, DIVU})).
REQ-022 The block SHALL deassert stall in the same cycle busy falls, so mfhi/mflo in D reads the new hi/lo value after one further stage.
REQ-023 The block SHALL ignore unknown md_op codes and SHALL leave state unchanged.

Reset
REQ-024 On reset=1 at an edge, the block SHALL set state=IDLE, counter=0, busy=0, hi=0 and lo=0.
REQ-025 Reset during BUSY SHALL abort the operation, and its result SHALL never be written.
REQ-026 Reset SHALL take priority over a simultaneous start.
REQ-027 stall SHALL be 0 on the cycle after reset unless md_use_d=1 and start=1 with a multi-cycle op.

Structure
REQ-028 The md_op encodings and the default cycle counts SHALL live in the shared mips package, which is also used by the control decoder.
REQ-029 The block SHALL have no sub-module; the result is computed from latched operands with one registered 64-bit result path.
REQ-030 The counter width SHALL be sufficient for max(MULT_CYCLES, DIV_CYCLES), and the block SHALL reject parameters above 15 at elaboration.

Verification
REQ-031 MULT with a=0xFFFFFFFE, b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV with a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU with b=0 and a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 MULT followed by mflo held in D -> stall=1 for 6 cycles (start cycle plus 5 busy), the instruction proceeds, and it reads the new lo.
REQ-035 MTHI with a=0xDEADBEEF while idle -> hi=0xDEADBEEF next edge, busy stays 0; start held during BUSY -> no change to counter or operands.
REQ-036 Reset asserted at busy cycle 3 of a DIV -> next cycle busy=0, hi=0, lo=0, and no later result write.
